// File: rtl/xrst_token_pkg.sv
// Token record types and ASCII tags shared by the settlement engine and its output FIFO.
package xrst_token_pkg;

  typedef enum logic [1:0] {
    CREDIT  = 2'd0,
    PENALTY = 2'd1,
    STAKE   = 2'd2
  } token_type_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 16;
  localparam int DEF_CH_W   = 2;

  localparam logic [7:0] TAG_CREDIT  = 8'h43;
  localparam logic [7:0] TAG_PENALTY = 8'h50;
  localparam logic [7:0] TAG_STAKE   = 8'h53;

  // Record at default widths; the engine declares a width-matched copy for other builds.
  typedef struct packed {
    token_type_e           ttype;
    logic [DEF_DATA_W-1:0] amount;
    logic [DEF_DATA_W-1:0] stake;
    logic [DEF_CH_W-1:0]   channel;
    logic [DEF_ID_W-1:0]   boundary_id;
    logic [31:0]           seq;
  } token_rec_t;

  function automatic logic [7:0] token_tag(input token_type_e t);
    case (t)
      CREDIT:  return TAG_CREDIT;
      PENALTY: return TAG_PENALTY;
      default: return TAG_STAKE;
    endcase
  endfunction

endpackage

// File: rtl/xrst_token_fifo.sv
// Synchronous show-ahead record FIFO; head visible the cycle after push, popped on i_pop.
// Pushes while full are dropped; the engine's reservation keeps that from happening.
module xrst_token_fifo
  import xrst_token_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = token_rec_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  rec_t          i_push_rec,
  input  logic          i_pop,
  output logic          o_head_vld,
  output rec_t          o_head_rec,
  output logic [CW-1:0] o_count
);

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_push_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Empty head reads as zero so the outputs are clean after reset.
  assign o_head_vld = !w_empty;
  assign o_head_rec = w_empty ? '0 : r_mem[r_rd];
  assign o_count    = r_cnt;

endmodule

// File: rtl/xrst_token_settlement_engine.sv
// Nets credit/penalty evidence into typed token records per channel; accept->out_valid 2 edges,
// in_ready reserves FIFO space for the stage-1 record. XRST_TOKEN_ID_EN adds out_token_id.
module xrst_token_settlement_engine
  import xrst_token_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  NUM_CH      = 4,
  parameter int  FIFO_DEPTH  = 8,
  parameter int  STAKE_SHIFT = 3,
  parameter int  ID_W        = 16,
  localparam int CH_W        = $clog2(NUM_CH),
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_channel,
  input  logic [ID_W-1:0]   in_boundary_id,
  input  logic [DATA_W-1:0] in_credit,
  input  logic [DATA_W-1:0] in_penalty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_type,
  output logic [DATA_W-1:0] out_amount,
  output logic [DATA_W-1:0] out_stake_adj,
  output logic [CH_W-1:0]   out_channel,
  output logic [ID_W-1:0]   out_boundary_id,
  output logic [31:0]       out_seq,
  input  logic [CH_W-1:0]   query_channel,
  output logic [DATA_W:0]   query_balance,
  output logic [NUM_CH-1:0] sat_flags,
  output logic [CNT_W-1:0]  fifo_count,
  input  logic              clear_flags
`ifdef XRST_TOKEN_ID_EN
  ,
  output logic [ID_W+47:0]  out_token_id
`endif
);

  typedef struct packed {
    token_type_e       ttype;
    logic [DATA_W-1:0] amount;
    logic [DATA_W-1:0] stake;
    logic [CH_W-1:0]   channel;
    logic [ID_W-1:0]   boundary_id;
    logic [31:0]       seq;
`ifdef XRST_TOKEN_ID_EN
    logic [ID_W+47:0]  token_id;
`endif
  } rec_t;

  localparam logic signed [DATA_W+1:0] BAL_MAX = {2'b00, {DATA_W{1'b1}}};
  localparam logic signed [DATA_W+1:0] BAL_MIN = {2'b11, {DATA_W{1'b0}}};

  logic signed [DATA_W:0]   r_bal [NUM_CH];
  logic [31:0]              r_seq [NUM_CH];
  logic [NUM_CH-1:0]        r_sat;
  logic                     r_s1_vld;
  rec_t                     r_s1_rec;

  logic                     w_acc;
  token_type_e              w_type;
  logic [DATA_W-1:0]        w_amount;
  logic [DATA_W-1:0]        w_stake;
  logic [31:0]              w_seq;
  rec_t                     w_rec;
  logic signed [DATA_W+1:0] w_cur;
  logic signed [DATA_W+1:0] w_cr;
  logic signed [DATA_W+1:0] w_pn;
  logic signed [DATA_W+1:0] w_sum;
  logic signed [DATA_W:0]   w_bal_nxt;
  logic                     w_clamp;
  logic [NUM_CH-1:0]        w_sat_nxt;
  logic [CNT_W:0]           w_reserved;
  rec_t                     w_head;

  // Count the in-flight stage-1 record so a push can never find the FIFO full.
  assign w_reserved = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(r_s1_vld);
  assign in_ready   = (w_reserved < (CNT_W+1)'(FIFO_DEPTH));
  assign w_acc      = in_valid && in_ready;
  assign w_seq      = r_seq[in_channel];

  always_comb begin
    w_type   = STAKE;
    w_amount = '0;
    w_stake  = '0;
    if (in_credit > in_penalty) begin
      w_type   = CREDIT;
      w_amount = in_credit - in_penalty;
    end else if (in_penalty > in_credit) begin
      w_type   = PENALTY;
      w_amount = in_penalty - in_credit;
      w_stake  = w_amount >> STAKE_SHIFT;
    end
  end

  always_comb begin
    w_rec             = '0;
    w_rec.ttype       = w_type;
    w_rec.amount      = w_amount;
    w_rec.stake       = w_stake;
    w_rec.channel     = in_channel;
    w_rec.boundary_id = in_boundary_id;
    w_rec.seq         = w_seq;
`ifdef XRST_TOKEN_ID_EN
    w_rec.token_id    = {in_boundary_id, w_seq, token_tag(w_type), 8'(in_channel)};
`endif
  end

  // Balance is read straight from the register array, so back-to-back accepts see prior updates.
  always_comb begin
    w_cur     = {r_bal[in_channel][DATA_W], r_bal[in_channel]};
    w_cr      = {2'b00, in_credit};
    w_pn      = {2'b00, in_penalty};
    w_sum     = w_cur + w_cr - w_pn;
    w_clamp   = 1'b0;
    w_bal_nxt = w_sum[DATA_W:0];
    if (w_sum > BAL_MAX) begin
      w_clamp   = 1'b1;
      w_bal_nxt = BAL_MAX[DATA_W:0];
    end else if (w_sum < BAL_MIN) begin
      w_clamp   = 1'b1;
      w_bal_nxt = BAL_MIN[DATA_W:0];
    end
  end

  always_comb begin
    w_sat_nxt = clear_flags ? '0 : r_sat;
    if (w_acc && w_clamp) w_sat_nxt[in_channel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_rec <= '0;
      r_sat    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_bal[i] <= '0;
        r_seq[i] <= '0;
      end
    end else begin
      r_s1_vld <= w_acc;
      r_sat    <= w_sat_nxt;
      if (w_acc) begin
        r_s1_rec          <= w_rec;
        r_bal[in_channel] <= w_bal_nxt;
        r_seq[in_channel] <= w_seq + 32'd1;
      end
    end
  end

  xrst_token_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_s1_vld),
    .i_push_rec (r_s1_rec),
    .i_pop      (out_ready),
    .o_head_vld (out_valid),
    .o_head_rec (w_head),
    .o_count    (fifo_count)
  );

  assign out_type        = w_head.ttype;
  assign out_amount      = w_head.amount;
  assign out_stake_adj   = w_head.stake;
  assign out_channel     = w_head.channel;
  assign out_boundary_id = w_head.boundary_id;
  assign out_seq         = w_head.seq;
  assign query_balance   = r_bal[query_channel];
  assign sat_flags       = r_sat;
`ifdef XRST_TOKEN_ID_EN
  assign out_token_id    = w_head.token_id;
`endif

endmodule

// File: tb/tb_xrst_token_settlement_engine.sv
// Directed self-checking bench for xrst_token_settlement_engine at default parameters.
module tb_xrst_token_settlement_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_channel;
  logic [15:0] in_boundary_id;
  logic [31:0] in_credit;
  logic [31:0] in_penalty;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_type;
  logic [31:0] out_amount;
  logic [31:0] out_stake_adj;
  logic [1:0]  out_channel;
  logic [15:0] out_boundary_id;
  logic [31:0] out_seq;
  logic [1:0]  query_channel;
  logic [32:0] query_balance;
  logic [3:0]  sat_flags;
  logic [3:0]  fifo_count;
  logic        clear_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xrst_token_settlement_engine dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_channel      (in_channel),
    .in_boundary_id  (in_boundary_id),
    .in_credit       (in_credit),
    .in_penalty      (in_penalty),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_type        (out_type),
    .out_amount      (out_amount),
    .out_stake_adj   (out_stake_adj),
    .out_channel     (out_channel),
    .out_boundary_id (out_boundary_id),
    .out_seq         (out_seq),
    .query_channel   (query_channel),
    .query_balance   (query_balance),
    .sat_flags       (sat_flags),
    .fifo_count      (fifo_count),
    .clear_flags     (clear_flags)
  );

  // Presents one evidence beat and returns 1ns after the edge that accepted it.
  task automatic send(input logic [1:0] ch, input logic [15:0] bid, input logic [31:0] cr, input logic [31:0] pn);
    bit done = 1'b0;
    in_valid = 1'b1; in_channel = ch; in_boundary_id = bid; in_credit = cr; in_penalty = pn;
    for (int c = 0; c < 40 && !done; c++) begin
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL send_accept ch=%0d: in_ready stayed 0, required 1", ch); end
  endtask

  task automatic wait_out(input string tag);
    int c = 0;
    while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_timeout: out_valid=%0b required 1", tag, out_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_channel = '0; in_boundary_id = '0; in_credit = '0; in_penalty = '0;
    out_ready = 1'b0; query_channel = '0; clear_flags = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d required 0", fifo_count); end
    checks++; if (sat_flags !== 4'd0) begin errors++; $display("FAIL rst_sat_flags: got %b required 0000", sat_flags); end
    checks++; if (query_balance !== 33'd0) begin errors++; $display("FAIL rst_balance: got %h required 0", query_balance); end
    checks++; if (out_seq !== 32'd0 || out_amount !== 32'd0) begin errors++; $display("FAIL rst_out_fields: seq %0d amount %0d required 0 0", out_seq, out_amount); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_credit();
    out_ready = 1'b1; query_channel = 2'd0;
    send(2'd0, 16'h1234, 32'd100, 32'd30);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL credit_latency: out_valid %0b one edge after accept, required 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL credit_valid: got %0b required 1", out_valid); end
    checks++; if (out_type !== 2'd0 || out_amount !== 32'd70 || out_stake_adj !== 32'd0) begin errors++; $display("FAIL credit_rec: type %0d amount %0d stake %0d required 0 70 0", out_type, out_amount, out_stake_adj); end
    checks++; if (out_seq !== 32'd0 || out_channel !== 2'd0 || out_boundary_id !== 16'h1234) begin errors++; $display("FAIL credit_meta: seq %0d ch %0d id %h required 0 0 1234", out_seq, out_channel, out_boundary_id); end
    checks++; if (query_balance !== 33'd70) begin errors++; $display("FAIL credit_balance: got %h required 46", query_balance); end
  endtask

  task automatic test_penalty();
    query_channel = 2'd1;
    send(2'd1, 16'h0042, 32'd10, 32'd90);
    wait_out("penalty");
    checks++; if (out_type !== 2'd1 || out_amount !== 32'd80 || out_stake_adj !== 32'd10) begin errors++; $display("FAIL penalty_rec: type %0d amount %0d stake %0d required 1 80 10", out_type, out_amount, out_stake_adj); end
    checks++; if (out_seq !== 32'd0 || out_channel !== 2'd1) begin errors++; $display("FAIL penalty_meta: seq %0d ch %0d required 0 1", out_seq, out_channel); end
    checks++; if (query_balance !== 33'h1FFFFFFB0) begin errors++; $display("FAIL penalty_balance: got %h required 1ffffffb0", query_balance); end
  endtask

  task automatic test_stake();
    query_channel = 2'd2;
    send(2'd2, 16'h0007, 32'd55, 32'd55);
    wait_out("stake");
    checks++; if (out_type !== 2'd2 || out_amount !== 32'd0 || out_stake_adj !== 32'd0 || out_seq !== 32'd0) begin errors++; $display("FAIL stake_rec: type %0d amount %0d stake %0d seq %0d required 2 0 0 0", out_type, out_amount, out_stake_adj, out_seq); end
    checks++; if (query_balance !== 33'd0) begin errors++; $display("FAIL stake_balance: got %h required 0", query_balance); end
    send(2'd2, 16'h0008, 32'd5, 32'd5);
    wait_out("stake_seq");
    checks++; if (out_seq !== 32'd1 || out_boundary_id !== 16'h0008) begin errors++; $display("FAIL stake_seq: seq %0d id %h required 1 0008", out_seq, out_boundary_id); end
  endtask

  task automatic test_back_to_back();
    int  n = 0;
    bit  rdy;
    @(posedge clk); #1;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL b2b_start_count: got %0d required 0", fifo_count); end
    out_ready = 1'b0; query_channel = 2'd0;
    in_valid = 1'b1; in_channel = 2'd0; in_boundary_id = 16'h00B0; in_credit = 32'd1; in_penalty = 32'd0;
    for (int c = 0; c < 20 && n < 10; c++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin n++; in_credit = 32'(n + 1); end
    end
    in_valid = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_accepted: got %0d required 8", n); end
    checks++; if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: count %0d in_ready %0b required 8 0", fifo_count, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_amount !== 32'd1 || out_seq !== 32'd1) begin errors++; $display("FAIL b2b_hold: valid %0b amount %0d seq %0d required 1 1 1", out_valid, out_amount, out_seq); end
    checks++; if (query_balance !== 33'd106) begin errors++; $display("FAIL b2b_balance: got %0d required 106", query_balance); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1 || out_amount !== 32'(k + 1) || out_seq !== 32'(k + 1)) begin errors++; $display("FAIL b2b_drain_%0d: valid %0b amount %0d seq %0d required 1 %0d %0d", k, out_valid, out_amount, out_seq, k + 1, k + 1); end
      @(posedge clk); #1;
    end
    checks++; if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: count %0d valid %0b required 0 0", fifo_count, out_valid); end
  endtask

  task automatic test_saturation();
    query_channel = 2'd3;
    send(2'd3, 16'h0009, 32'hFFFF_FFFF, 32'd0);
    checks++; if (query_balance !== 33'h0FFFFFFFF || sat_flags !== 4'b0000) begin errors++; $display("FAIL sat_first: bal %h flags %b required 0ffffffff 0000", query_balance, sat_flags); end
    send(2'd3, 16'h0009, 32'hFFFF_FFFF, 32'd0);
    checks++; if (query_balance !== 33'h0FFFFFFFF || sat_flags !== 4'b1000) begin errors++; $display("FAIL sat_clamp_hi: bal %h flags %b required 0ffffffff 1000", query_balance, sat_flags); end
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    checks++; if (sat_flags !== 4'b0000) begin errors++; $display("FAIL sat_clear: got %b required 0000", sat_flags); end
    send(2'd3, 16'h0009, 32'hFFFF_FFFF, 32'd0);
    query_channel = 2'd2;
    send(2'd2, 16'h000A, 32'd0, 32'hFFFF_FFFF);
    checks++; if (query_balance !== 33'h100000001 || sat_flags !== 4'b1000) begin errors++; $display("FAIL sat_neg_first: bal %h flags %b required 100000001 1000", query_balance, sat_flags); end
    clear_flags = 1'b1;
    send(2'd2, 16'h000B, 32'd0, 32'hFFFF_FFFF);
    clear_flags = 1'b0;
    checks++; if (query_balance !== 33'h100000000 || sat_flags !== 4'b0100) begin errors++; $display("FAIL sat_clear_race: bal %h flags %b required 100000000 0100", query_balance, sat_flags); end
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; query_channel = 2'd1;
    for (int i = 0; i < 3; i++) send(2'd1, 16'h0055, 32'(i + 1), 32'd0);
    @(posedge clk); #1;
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL rmid_queued: got %0d required 3", fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL rmid_flush: valid %0b count %0d required 0 0", out_valid, fifo_count); end
    checks++; if (query_balance !== 33'd0 || sat_flags !== 4'b0000) begin errors++; $display("FAIL rmid_state: bal %h flags %b required 0 0000", query_balance, sat_flags); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send(2'd1, 16'h00AA, 32'd7, 32'd0);
    wait_out("rmid");
    checks++; if (out_seq !== 32'd0 || out_amount !== 32'd7 || out_boundary_id !== 16'h00AA) begin errors++; $display("FAIL rmid_first_rec: seq %0d amount %0d id %h required 0 7 00aa", out_seq, out_amount, out_boundary_id); end
    checks++; if (query_balance !== 33'd7) begin errors++; $display("FAIL rmid_balance: got %h required 7", query_balance); end
  endtask

  initial begin
    test_reset();
    test_credit();
    test_penalty();
    test_stake();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
